// File: rtl/eth_frame_tx.sv
// -----------------------------------------------------------------------------
// eth_frame_tx
//
// Turns a payload dibit stream into an RMII transmit frame. Each frame is sent
// as follows:
//   - a 32-dibit preamble/SFD,
//   - the payload dibits, exactly as supplied,
//   - the 32-bit FCS, sent as 16 dibits,
//   - a 48-cycle inter-frame gap.
// Payload length is unrestricted (at least one dibit). No padding is added.
//
// Ports
//   clk_in         50 MHz RMII reference clock; everything is rising-edge.
//   rst_in         synchronous active-high reset. It aborts a frame at once.
//   trigger_in     start-of-frame request. It is only honoured in idle.
//   data_in        payload dibit. Bit 0 goes on the wire first.
//   last_dibit_in  marks the data_in dibit sampled with it as the final one.
//   ready_out      high exactly while idle.
//   data_ready_out registered request to upstream. Upstream answers each
//                  request cycle with one dibit on the following cycle.
//   axiov          registered RMII TX_EN.
//   axiod          registered RMII TXD.
//
// Timing relative to the trigger-sampling edge T0 (cycle k = after edge T0+k-1)
//   cycles 1..32          : preamble dibits 0..31
//   cycle  31             : data_ready_out rises
//   edges  T0+32 ..       : payload sampled; each dibit goes on the wire next
//                           cycle
//   cycles 33+N .. 48+N   : FCS dibits
//   cycles 49+N .. 96+N   : gap
//   cycle  97+N           : back in idle
// -----------------------------------------------------------------------------
module eth_frame_tx (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       trigger_in,
   input  logic [1:0] data_in,
   input  logic       last_dibit_in,
   output logic       ready_out,
   output logic       data_ready_out,
   output logic       axiov,
   output logic [1:0] axiod
);

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StData,
      StCrc,
      StGap
   } state_e;

   localparam logic [31:0] CrcPoly = 32'hEDB88320;
   localparam logic [31:0] CrcInit = 32'hFFFFFFFF;

   // The preamble counter indexes the dibit currently on the wire.
   // Data is requested one cycle before it is needed. Upstream answers one
   // cycle later, so the request rises while dibit 30 is on the wire.
   localparam logic [5:0] PreReqCnt  = 6'd29;
   localparam logic [5:0] PreLastCnt = 6'd30;
   localparam logic [5:0] CrcLastCnt = 6'd15;
   // Gap count 0 still shows the final FCS dibit. Counts 1..48 are the idle
   // wire cycles.
   localparam logic [5:0] GapLastCnt = 6'd48;

   localparam logic [1:0] PreDibit = 2'b01;
   localparam logic [1:0] SfdDibit = 2'b11;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d;
   logic        data_ready_q, data_ready_d;
   logic        axiov_q, axiov_d;
   logic [1:0]  axiod_q, axiod_d;

   // Reflected CRC-32 step over one dibit. Bit 0 is processed first.
   function automatic logic [31:0] crc_dibit(input logic [31:0] crc,
                                             input logic [1:0]  d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 2; i++) begin
         if (c[0] ^ d[i]) begin
            c = (c >> 1) ^ CrcPoly;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      data_ready_d = data_ready_q;
      axiov_d      = axiov_q;
      axiod_d      = axiod_q;

      unique case (state_q)
         StIdle: begin
            axiov_d      = 1'b0;
            axiod_d      = 2'b00;
            data_ready_d = 1'b0;
            if (trigger_in) begin
               state_d = StPreamble;
               cnt_d   = 6'd0;
               crc_d   = CrcInit;
               axiov_d = 1'b1;
               axiod_d = PreDibit;
            end
         end

         StPreamble: begin
            axiov_d = 1'b1;
            axiod_d = PreDibit;
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == PreReqCnt) begin
               data_ready_d = 1'b1;
            end
            if (cnt_q == PreLastCnt) begin
               axiod_d = SfdDibit;
               state_d = StData;
               cnt_d   = 6'd0;
            end
         end

         StData: begin
            axiov_d = 1'b1;
            axiod_d = data_in;
            crc_d   = crc_dibit(crc_q, data_in);
            if (last_dibit_in) begin
               data_ready_d = 1'b0;
               state_d      = StCrc;
               cnt_d        = 6'd0;
            end
         end

         StCrc: begin
            // The CRC register is frozen here. Send its complement LSB first.
            axiov_d = 1'b1;
            axiod_d = ~crc_q[{cnt_q[3:0], 1'b0} +: 2];
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == CrcLastCnt) begin
               state_d = StGap;
               cnt_d   = 6'd0;
            end
         end

         StGap: begin
            axiov_d = 1'b0;
            axiod_d = 2'b00;
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == GapLastCnt) begin
               state_d = StIdle;
               cnt_d   = 6'd0;
            end
         end

         default: begin
            state_d      = StIdle;
            cnt_d        = 6'd0;
            data_ready_d = 1'b0;
            axiov_d      = 1'b0;
            axiod_d      = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= StIdle;
         cnt_q        <= 6'd0;
         crc_q        <= CrcInit;
         data_ready_q <= 1'b0;
         axiov_q      <= 1'b0;
         axiod_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         crc_q        <= crc_d;
         data_ready_q <= data_ready_d;
         axiov_q      <= axiov_d;
         axiod_q      <= axiod_d;
      end
   end

   assign ready_out      = (state_q == StIdle);
   assign data_ready_out = data_ready_q;
   assign axiov          = axiov_q;
   assign axiod          = axiod_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_eth_frame_tx
//
// Bench for eth_frame_tx. Expected wire activity is derived cycle by cycle
// from the frame layout, counted from the trigger-sampling edge. The FCS comes
// from a plain bit-serial CRC-32 over the payload. For the "123456789" frame it
// is the published check value instead.
// -----------------------------------------------------------------------------
module tb_eth_frame_tx;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       trigger_in;
   logic [1:0] data_in;
   logic       last_dibit_in;
   logic       ready_out;
   logic       data_ready_out;
   logic       axiov;
   logic [1:0] axiod;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [1:0] payload[$];

   eth_frame_tx dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .trigger_in    (trigger_in),
      .data_in       (data_in),
      .last_dibit_in (last_dibit_in),
      .ready_out     (ready_out),
      .data_ready_out(data_ready_out),
      .axiov         (axiov),
      .axiod         (axiod)
   );

   always #10 clk_in = ~clk_in;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // FCS as transmitted: complement of the reflected CRC-32 over the payload.
   function automatic logic [31:0] ref_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (payload[i]) begin
         for (int b = 0; b < 2; b++) begin
            if ((c[0] ^ payload[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else c = c >> 1;
         end
      end
      return ~c;
   endfunction

   // Returns {ready_out, data_ready_out, axiov, axiod} for cycle k of a frame.
   function automatic logic [4:0] expected_vec(input int k, input int n, input logic [31:0] fcs);
      logic       rdy;
      logic       dr;
      logic       v;
      logic [1:0] d;
      int         j;
      rdy = (k >= 97 + n);
      dr  = (k >= 31) && (k <= 31 + n);
      v   = (k >= 1) && (k <= 48 + n);
      if (k <= 31)            d = 2'b01;
      else if (k == 32)       d = 2'b11;
      else if (k <= 32 + n)   d = payload[k - 33];
      else if (k <= 48 + n) begin
         j = k - 33 - n;
         d = fcs[2 * j +: 2];
      end else                d = 2'b00;
      return {rdy, dr, v, d};
   endfunction

   // Sends the current payload. It optionally pulses trigger_in during the
   // frame. If abort_k is non-zero, reset (with trigger held) is asserted in
   // cycle abort_k.
   task automatic run_frame(input logic [31:0] fcs, input bit noise, input int abort_k);
      int n;
      int w;
      int kend;
      n = payload.size();
      w = 0;
      while (!ready_out && w < 300) begin
         @(negedge clk_in);
         w++;
      end
      check_eq("ready_before_trigger", 32'(ready_out), 32'd1);
      trigger_in = 1'b1;
      kend = (abort_k != 0) ? abort_k : 98 + n;
      for (int k = 1; k <= kend; k++) begin
         @(negedge clk_in);
         check_eq($sformatf("n%0d_cyc%0d", n, k),
                  32'({ready_out, data_ready_out, axiov, axiod}), 32'(expected_vec(k, n, fcs)));
         if (k >= 32 && k <= 31 + n) begin
            data_in       = payload[k - 32];
            last_dibit_in = (k == 31 + n);
         end else begin
            data_in       = 2'($urandom);
            last_dibit_in = 1'($urandom);
         end
         if (noise && k <= 96 + n) trigger_in = ($urandom_range(0, 3) == 0);
         else trigger_in = 1'b0;
         if (k == abort_k) begin
            rst_in     = 1'b1;
            trigger_in = 1'b1;
         end
      end
      if (abort_k != 0) begin
         @(negedge clk_in);
         check_eq("abort_idle", 32'({ready_out, data_ready_out, axiov, axiod}), 32'b10000);
         rst_in     = 1'b0;
         trigger_in = 1'b0;
         @(negedge clk_in);
         check_eq("abort_no_trigger", 32'({ready_out, data_ready_out, axiov, axiod}), 32'b10000);
      end
      trigger_in    = 1'b0;
      last_dibit_in = 1'b0;
   endtask

   initial begin
      string      s;
      logic [7:0] b;
      int         len;

      rst_in        = 1'b1;
      trigger_in    = 1'b0;
      data_in       = 2'b00;
      last_dibit_in = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         check_eq($sformatf("reset_idle%0d", i),
                  32'({ready_out, data_ready_out, axiov, axiod}), 32'b10000);
      end

      // "123456789": trailer 26 39 F4 CB, i.e. FCS word CBF43926.
      s = "123456789";
      payload.delete();
      for (int i = 0; i < s.len(); i++) begin
         b = s[i];
         for (int j = 0; j < 4; j++) payload.push_back(b[2 * j +: 2]);
      end
      run_frame(32'hCBF43926, 1'b1, 0);

      // Single-dibit payload.
      payload.delete();
      payload.push_back(2'b10);
      run_frame(ref_fcs(), 1'b1, 0);

      // Reset while payload dibit 10 is on the wire, then the same frame in full.
      payload.delete();
      for (int i = 0; i < 40; i++) payload.push_back(2'($urandom));
      run_frame(ref_fcs(), 1'b0, 43);
      run_frame(ref_fcs(), 1'b0, 0);

      // Random payloads.
      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(1, 80);
         payload.delete();
         for (int i = 0; i < len; i++) payload.push_back(2'($urandom));
         run_frame(ref_fcs(), 1'($urandom), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 SHALL have clk_in, input, 1: single clock, 50 MHz RMII reference; all logic on rising edge.
REQ-002 SHALL have rst_in, input, 1: synchronous, active-high reset.
REQ-003 SHALL have trigger_in, input, 1: start-of-frame request; sampled only in IDLE.
REQ-004 SHALL have data_in, input, 2: payload dibit, bit 0 first on wire.
REQ-005 SHALL have last_dibit_in, input, 1: marks the data_in dibit sampled with it as final payload dibit.
REQ-006 SHALL have ready_out, output, 1: high exactly while in IDLE.
REQ-007 SHALL have data_ready_out, output, 1: registered; upstream must present one new dibit per cycle while high.
REQ-008 SHALL have axiov, output, 1: registered RMII TX_EN.
REQ-009 SHALL have axiod, output, 2: registered RMII TXD.

Function
REQ-010 SHALL implement states IDLE, PREAMBLE, DATA, CRC, GAP.
REQ-011 IDLE: trigger_in=1 -> PREAMBLE next cycle, counter cleared; otherwise stay; axiov=0, axiod=0.
REQ-012 PREAMBLE SHALL drive 32 dibits with axiov=1: dibits 0-30 = 2'b01, dibit 31 = 2'b11 (0x55 x7, 0xD5, LSB first).
REQ-013 data_ready_out SHALL rise in the cycle axiod carries preamble dibit 30 and stay high continuously until the edge that samples last_dibit_in=1 in DATA; no backpressure.
REQ-014 DATA: each edge samples data_in; sampled dibit SHALL appear on axiod the next cycle; first payload dibit on wire exactly 2 cycles after data_ready_out first rises.
REQ-015 DATA SHALL feed each sampled dibit into CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF), data_in[0] before data_in[1].
REQ-016 Dibit sampled with last_dibit_in=1: transmitted normally, CRC updated, data_ready_out low next cycle, state -> CRC.
REQ-017 CRC SHALL transmit ~crc as 16 dibits, LSB first, immediately following last payload dibit (no gap cycle), axiov=1.
REQ-018 GAP SHALL hold axiov=0, axiod=0, ready_out=0 for 48 cycles (96-bit IFG), then -> IDLE.
REQ-019 trigger_in outside IDLE SHALL be ignored (not queued).
REQ-020 last_dibit_in and data_in outside DATA SHALL be ignored.
REQ-021 SHALL NOT pad or enforce min/max length; payload length arbitrary (>=1 dibit), counters for preamble/CRC/gap only.
REQ-022 axiov SHALL be continuous high from first preamble dibit to last CRC dibit: 32 + N + 16 cycles for N payload dibits.

Reset
REQ-023 rst_in=1 at an edge SHALL force IDLE, axiov=0, axiod=0, data_ready_out=0, CRC=0xFFFFFFFF, counters 0; ready_out=1 following cycle.
REQ-024 Reset mid-frame SHALL truncate immediately (no CRC, no GAP); trigger_in ignored while rst_in=1.

Verification
REQ-025 Reset then idle 10 cycles -> ready_out=1, axiov=0, axiod=0, data_ready_out=0 throughout.
REQ-026 Trigger, payload ASCII "123456789" (36 dibits) -> wire: 31x01, 11, 36 payload dibits, trailer bytes 0x26 0x39 0xF4 0xCB LSB-first; axiov high 84 cycles; then 48 idle cycles; ready_out rises cycle 133 after trigger edge.
REQ-027 Handshake timing: data_ready_out rises 31 cycles after trigger sample edge; first payload dibit on axiod 2 cycles later; data_ready_out falls cycle after last_dibit_in sampled.
REQ-028 Single-dibit payload 2'b10 with last_dibit_in=1 -> 1 payload dibit, 16 CRC dibits, axiov high 49 cycles.
REQ-029 trigger_in pulsed during DATA and GAP -> ignored; second frame starts only on trigger in IDLE.
REQ-030 rst_in asserted at payload dibit 10 -> axiov=0 next cycle, no CRC dibits, ready_out=1; next trigger yields correct full frame.
